// File: rtl/icache_pkg.sv
// Shared definitions for the parameterised instruction cache: FSM state
// encoding and the helpers that derive address-field widths from the
// cache geometry.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Word-offset field width inside a line.
    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Set-index field width.
    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    // Way number / LRU age width; a direct-mapped cache still needs one bit.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Tag field width: whatever is left above index and offset.
    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - index_w(sets) - offset_w(line_words);
    endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU bookkeeping for one cache set. Each way carries an age
// (0 = most recently used, WAYS-1 = least recently used). The victim is the
// lowest-numbered invalid way, otherwise the oldest way.
module icache_lru
    import icache_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    touch,
    input  logic [way_w(WAYS)-1:0]  touch_way,
    input  logic [WAYS-1:0]         valid,
    output logic [way_w(WAYS)-1:0]  victim
);

    localparam int AGE_W = way_w(WAYS);

    logic [AGE_W-1:0] ages [WAYS];
    logic [AGE_W-1:0] touch_age;

    assign touch_age = ages[touch_way];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [AGE_W-1:0] age_reg;

            // Touched way becomes youngest; every way younger than it ages by one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    age_reg <= AGE_W'(gi);
                end else if (touch) begin
                    if (touch_way == AGE_W'(gi)) begin
                        age_reg <= '0;
                    end else if (age_reg < touch_age) begin
                        age_reg <= age_reg + 1'b1;
                    end
                end
            end

            assign ages[gi] = age_reg;
        end
    endgenerate

    // Oldest way first, then let the lowest-numbered invalid way override it.
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ages[w] == AGE_W'(WAYS - 1)) begin
                victim = AGE_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = AGE_W'(w);
            end
        end
    end

endmodule

// File: rtl/instr_cache_param.sv
// Parameterised set-associative instruction cache. Hits are served
// combinationally from IDLE; a miss requests the common bus, streams a full
// line into the victim way, then returns through DONE so the fetch hits.
module instr_cache_param
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PrRd,
    input  logic [ADDR_W-1:0] Address,
    output logic [ADDR_W-1:0] Data_Bus,
    output logic              CPU_stall,
    input  logic              Flush,
    output logic              Com_Bus_Req_proc,
    input  logic              Com_Bus_Gnt_proc,
    output logic [ADDR_W-1:0] Address_Com,
    input  logic [ADDR_W-1:0] Data_Bus_Com,
    input  logic              Data_in_Bus,
    output logic [15:0]       Miss_cnt
);

    localparam int OFF_W   = offset_w(LINE_WORDS);
    localparam int IDX_W   = index_w(SETS);
    localparam int WAY_W   = way_w(WAYS);
    localparam int TAG_W   = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int LINE_W  = ADDR_W - OFF_W;
    localparam int TAG_AW  = IDX_W + WAY_W;
    localparam int DATA_AW = IDX_W + WAY_W + OFF_W;

    // Address fields of the current fetch.
    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;

    assign a_off = Address[OFF_W-1:0];
    assign a_idx = Address[OFF_W +: IDX_W];
    assign a_tag = Address[ADDR_W-1 -: TAG_W];

    // Controller state.
    state_t            state_reg, state_next;
    logic [OFF_W-1:0]  beat_reg;
    logic [15:0]       miss_cnt_reg;
    logic [LINE_W-1:0] line_reg;      // {tag, index} of the line being filled
    logic [WAY_W-1:0]  victim_reg;
    logic              flushed_reg;   // a flush landed during this fill

    // Storage: valid bits reset, tag/data arrays do not.
    logic [WAYS-1:0]   valid_reg [SETS];
    logic [TAG_W-1:0]  tag_mem   [2**TAG_AW];
    logic [ADDR_W-1:0] data_mem  [2**DATA_AW];

    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign fill_idx = line_reg[IDX_W-1:0];
    assign fill_tag = line_reg[LINE_W-1 -: TAG_W];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             idle_rd, miss_start, hit_touch, beat_we, fill_last;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] set_victim [SETS];

    // Tag compare across all ways of the indexed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_reg[a_idx][w] && tag_mem[{a_idx, WAY_W'(w)}] == a_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign idle_rd    = (state_reg == IDLE) && PrRd;
    assign miss_start = idle_rd && !hit;
    assign hit_touch  = idle_rd && hit;
    assign beat_we    = (state_reg == FILL) && Data_in_Bus;
    assign fill_last  = beat_we && (beat_reg == OFF_W'(LINE_WORDS - 1));
    assign lru_way    = fill_last ? victim_reg : hit_way;

    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_set
            logic touch_en;

            assign touch_en = (hit_touch && (a_idx == IDX_W'(gi))) ||
                              (fill_last && (fill_idx == IDX_W'(gi)));

            icache_lru #(
                .WAYS (WAYS)
            ) u_lru (
                .clk       (clk),
                .rst_n     (rst_n),
                .touch     (touch_en),
                .touch_way (lru_way),
                .valid     (valid_reg[gi]),
                .victim    (set_victim[gi])
            );
        end
    endgenerate

    // Next-state and bus/stall outputs.
    always_comb begin
        state_next       = state_reg;
        Com_Bus_Req_proc = 1'b0;
        Address_Com      = '0;
        CPU_stall        = 1'b1;
        case (state_reg)
            IDLE: begin
                CPU_stall = PrRd && !hit;
                if (miss_start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                Com_Bus_Req_proc = 1'b1;
                if (Com_Bus_Gnt_proc) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                Com_Bus_Req_proc = 1'b1;
                Address_Com      = {line_reg, beat_reg};
                if (fill_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Hit data is only presented for a real hit in IDLE.
    assign Data_Bus = hit_touch ? data_mem[{a_idx, hit_way, a_off}] : '0;
    assign Miss_cnt = miss_cnt_reg;

    // State register, miss capture, beat counter and miss counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            beat_reg     <= '0;
            miss_cnt_reg <= '0;
            line_reg     <= '0;
            victim_reg   <= '0;
            flushed_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (miss_start) begin
                line_reg    <= Address[ADDR_W-1:OFF_W];
                victim_reg  <= set_victim[a_idx];
                flushed_reg <= 1'b0;
                if (miss_cnt_reg != 16'hFFFF) begin
                    miss_cnt_reg <= miss_cnt_reg + 16'd1;
                end
            end
            if ((state_reg == FILL) && Flush) begin
                flushed_reg <= 1'b1;
            end
            if (beat_we) begin
                // Wraps back to zero after the last beat.
                beat_reg <= beat_reg + 1'b1;
            end
        end
    end

    // Valid bits: flush wins; a completed fill validates its line unless flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
            end
        end else if (Flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
            end
        end else if (fill_last && !flushed_reg) begin
            valid_reg[fill_idx][victim_reg] <= 1'b1;
        end
    end

    // Line data and tag writes during refill.
    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_mem[{fill_idx, victim_reg, beat_reg}] <= Data_Bus_Com;
        end
        if (fill_last) begin
            tag_mem[{fill_idx, victim_reg}] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_instr_cache_param.sv
// Scoreboard bench for instr_cache_param with default geometry
// (32-bit words, 4 ways, 16 sets, 4-word lines). Stimulus pushes expected
// fetch data and refill beat addresses; a negedge monitor pops and compares.
module tb_instr_cache_param;

    localparam int LW      = 4;
    localparam int FL_NONE = -1;
    localparam int FL_HIT  = 99;

    logic        clk;
    logic        rst_n;
    logic        PrRd;
    logic [31:0] Address;
    logic [31:0] Data_Bus;
    logic        CPU_stall;
    logic        Flush;
    logic        Com_Bus_Req_proc;
    logic        Com_Bus_Gnt_proc;
    logic [31:0] Address_Com;
    logic [31:0] Data_Bus_Com;
    logic        Data_in_Bus;
    logic [15:0] Miss_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_miss_cnt = 0;

    logic [31:0] exp_data_q [$];
    logic [31:0] exp_addr_q [$];

    instr_cache_param #(
        .ADDR_W     (32),
        .WAYS       (4),
        .SETS       (16),
        .LINE_WORDS (LW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PrRd             (PrRd),
        .Address          (Address),
        .Data_Bus         (Data_Bus),
        .CPU_stall        (CPU_stall),
        .Flush            (Flush),
        .Com_Bus_Req_proc (Com_Bus_Req_proc),
        .Com_Bus_Gnt_proc (Com_Bus_Gnt_proc),
        .Address_Com      (Address_Com),
        .Data_Bus_Com     (Data_Bus_Com),
        .Data_in_Bus      (Data_in_Bus),
        .Miss_cnt         (Miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing memory contents: recognisable, address-derived words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: fetch data whenever a fetch completes, beat address whenever a beat is taken.
    always @(negedge clk) begin
        if (rst_n) begin
            if (PrRd && !CPU_stall) begin
                if (exp_data_q.size() == 0) begin
                    check("data_unexpected", Address, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_data_q.pop_front();
                    check("data", Data_Bus, e);
                    $display("fetch addr=0x%08h data=0x%08h exp=0x%08h", Address, Data_Bus, e);
                end
            end
            if (Data_in_Bus && Com_Bus_Req_proc) begin
                if (exp_addr_q.size() == 0) begin
                    check("beat_unexpected", Address_Com, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_addr_q.pop_front();
                    check("beat_addr", Address_Com, e);
                    $display("beat  addr=0x%08h exp=0x%08h", Address_Com, e);
                end
            end
        end
    end

    // One fetch; called and returns at #1 after a rising edge.
    task automatic fetch(input logic [31:0] a, input bit exp_miss, input int gnt_wait,
                         input bit gappy, input int flush_at);
        int  beat;
        int  cyc;
        bit  flushing;
        logic [31:0] base;
        flushing = (flush_at >= 0) && (flush_at < LW);
        base     = a & 32'hFFFF_FFFC;
        PrRd     = 1'b1;
        Address  = a;
        if (!flushing) exp_data_q.push_back(mem_word(a));
        if (flush_at == FL_HIT) Flush = 1'b1;
        #1;
        check("stall_now", {31'd0, CPU_stall}, {31'd0, exp_miss});
        @(posedge clk); #1;
        Flush = 1'b0;
        if (!exp_miss) begin
            check("hit_no_req", {31'd0, Com_Bus_Req_proc}, 32'd0);
            check("hit_miss_cnt", {16'd0, Miss_cnt}, exp_miss_cnt);
            PrRd = 1'b0;
            return;
        end
        if (exp_miss_cnt < 16'hFFFF) exp_miss_cnt++;
        check("miss_cnt", {16'd0, Miss_cnt}, exp_miss_cnt);
        for (int i = 0; i < LW; i++) exp_addr_q.push_back(base | i);
        for (int i = 0; i < gnt_wait; i++) begin
            check("req_wait", {31'd0, Com_Bus_Req_proc}, 32'd1);
            check("req_addr_com", Address_Com, 32'd0);
            @(posedge clk); #1;
        end
        check("req_at_gnt", {31'd0, Com_Bus_Req_proc}, 32'd1);
        Com_Bus_Gnt_proc = 1'b1;
        @(posedge clk); #1;
        Com_Bus_Gnt_proc = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < LW && cyc < 4 * LW) begin
            Data_in_Bus  = gappy ? cyc[0] : 1'b1;
            Data_Bus_Com = Data_in_Bus ? mem_word(base | beat) : 32'h0;
            Flush        = flushing && (beat == flush_at) && Data_in_Bus;
            check("fill_req", {31'd0, Com_Bus_Req_proc}, 32'd1);
            @(posedge clk); #1;
            if (Data_in_Bus) beat++;
            cyc++;
        end
        Data_in_Bus  = 1'b0;
        Data_Bus_Com = 32'h0;
        Flush        = 1'b0;
        check("done_stall", {31'd0, CPU_stall}, 32'd1);
        check("done_req", {31'd0, Com_Bus_Req_proc}, 32'd0);
        check("done_addr_com", Address_Com, 32'd0);
        if (flushing) PrRd = 1'b0;
        @(posedge clk); #1;
        if (flushing) return;
        check("refill_hit", {31'd0, CPU_stall}, 32'd0);
        @(posedge clk); #1;
        PrRd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        PrRd = 1'b0; Address = '0; Flush = 1'b0;
        Com_Bus_Gnt_proc = 1'b0; Data_Bus_Com = '0; Data_in_Bus = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_miss_cnt", {16'd0, Miss_cnt}, 32'd0);
        check("rst_req", {31'd0, Com_Bus_Req_proc}, 32'd0);
        check("rst_addr_com", Address_Com, 32'd0);
        check("rst_stall", {31'd0, CPU_stall}, 32'd0);
        check("rst_data", Data_Bus, 32'd0);

        // Cold miss with a three-cycle grant wait, then a hit on the same line.
        fetch(32'h40, 1'b1, 3, 1'b0, FL_NONE);
        fetch(32'h41, 1'b0, 0, 1'b0, FL_NONE);
        Address = 32'h41; PrRd = 1'b0; #1;
        check("idle_data_zero", Data_Bus, 32'd0);
        check("idle_stall_zero", {31'd0, CPU_stall}, 32'd0);
        @(posedge clk); #1;

        // Gapped refill: beats only on alternate cycles.
        fetch(32'h84, 1'b1, 1, 1'b1, FL_NONE);
        fetch(32'h87, 1'b0, 0, 1'b0, FL_NONE);
        fetch(32'h85, 1'b0, 0, 1'b0, FL_NONE);

        // Idle flush invalidates resident lines.
        Flush = 1'b1; @(posedge clk); #1; Flush = 1'b0;
        fetch(32'h41, 1'b1, 0, 1'b0, FL_NONE);
        Flush = 1'b1; @(posedge clk); #1; Flush = 1'b0;

        // LRU in set 0: 0x100 is oldest once 0x000 is re-touched.
        fetch(32'h000, 1'b1, 0, 1'b0, FL_NONE);
        fetch(32'h100, 1'b1, 0, 1'b0, FL_NONE);
        fetch(32'h200, 1'b1, 0, 1'b0, FL_NONE);
        fetch(32'h300, 1'b1, 0, 1'b0, FL_NONE);
        fetch(32'h000, 1'b0, 0, 1'b0, FL_NONE);
        fetch(32'h400, 1'b1, 0, 1'b0, FL_NONE);
        fetch(32'h002, 1'b0, 0, 1'b0, FL_NONE);
        fetch(32'h300, 1'b0, 0, 1'b0, FL_NONE);
        fetch(32'h100, 1'b1, 0, 1'b0, FL_NONE);

        // Flush coincident with a hit still returns data, then the line is gone.
        fetch(32'h003, 1'b0, 0, 1'b0, FL_HIT);
        fetch(32'h003, 1'b1, 0, 1'b0, FL_NONE);

        // Flush during beat 2: fill completes on the bus but is not installed.
        fetch(32'h88, 1'b1, 2, 1'b0, 2);
        fetch(32'h88, 1'b1, 0, 1'b0, FL_NONE);

        // Reset during fill beat 1 abandons the line.
        PrRd = 1'b1; Address = 32'h40;
        #1;
        check("rst_test_miss", {31'd0, CPU_stall}, 32'd1);
        @(posedge clk); #1;
        Com_Bus_Gnt_proc = 1'b1;
        @(posedge clk); #1;
        Com_Bus_Gnt_proc = 1'b0;
        exp_addr_q.push_back(32'h40);
        Data_in_Bus = 1'b1; Data_Bus_Com = mem_word(32'h40);
        @(posedge clk); #1;
        Data_in_Bus = 1'b0; Data_Bus_Com = '0;
        rst_n = 1'b0;
        #1;
        check("midfill_rst_req", {31'd0, Com_Bus_Req_proc}, 32'd0);
        check("midfill_rst_addr", Address_Com, 32'd0);
        check("midfill_rst_cnt", {16'd0, Miss_cnt}, 32'd0);
        exp_miss_cnt = 0;
        PrRd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fetch(32'h40, 1'b1, 0, 1'b0, FL_NONE);

        repeat (2) @(posedge clk);
        #1;
        check("data_q_drained", exp_data_q.size(), 32'd0);
        check("addr_q_drained", exp_addr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
